aes256_round_engine: RTL and testbench

//  Iterative AES-256 encryption core; directly downstream of the AES-256 key expansion block.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes256_round_engine.sv | 101 ++++++++++
 tb/tb_aes256_round_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, block width, GF(2^8) helpers and FSM encoding.
// Reused by the key expansion block and the future decrypt engine.
package aes_pkg;

    localparam int nr_lp      = 14;
    localparam int block_w_lp = 128;
    localparam int key_w_lp   = block_w_lp * (nr_lp + 1);

    // Byte 0 (row0,col0) is the most significant byte; bytes run column-major.
    typedef logic [0:15][7:0] aes_state_t;

    typedef enum logic [1:0] {eIdle, eRound, eDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [block_w_lp-1:0] round_key(input logic [0:key_w_lp-1] w,
                                                        input logic [3:0] r);
        return w[block_w_lp*r +: block_w_lp];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, pure combinational lookup.
module aes_sbox (
    input  logic [7:0] b,
    output logic [7:0] s
);

    always_comb begin
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes256_round_engine.sv
// Iterative AES-256 encryptor: one round per clock over a captured key schedule,
// single block in flight, ciphertext returned on a valid/yumi handshake.
module aes256_round_engine
    import aes_pkg::*;
#(
    parameter int nr_p    = nr_lp,
    parameter int key_w_p = block_w_lp * (nr_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic [block_w_lp-1:0] data_i,
    input  logic [0:key_w_p-1]    w_i,
    output logic                  v_o,
    output logic [block_w_lp-1:0] data_o,
    input  logic                  yumi_i
);

    localparam int rnd_w_lp = $clog2(nr_p + 1);

    // Entry r holds round key r; entry 0 is the leftmost 128 bits of w_i.
    typedef logic [0:nr_p][block_w_lp-1:0] sched_t;

    state_e              state_r, state_n;
    aes_state_t          st_r;
    sched_t              rk_r;
    logic [rnd_w_lp-1:0] rnd_r;

    aes_state_t sb, sr, mc, round_out;
    logic       last_round;

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .b (st_r[i]),
            .s (sb[i])
        );
    end

    // Row r of column c takes the byte from column (c+r) mod 4: left rotate by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c + r] = sb[4*((c + r) % 4) + r];
        end
        assign mc[4*c +: 4] = mix_col(sr[4*c +: 4]);
    end

    assign last_round = (rnd_r == rnd_w_lp'(nr_p));
    assign round_out  = (last_round ? sr : mc) ^ rk_r[rnd_r];

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= eIdle;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        unique case (state_r)
            eIdle: begin
                ready_o = 1'b1;
                if (v_i) state_n = eRound;
            end
            eRound: if (last_round) state_n = eDone;
            eDone: begin
                v_o = 1'b1;
                if (yumi_i) state_n = eIdle;
            end
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_r  <= '0;
            rk_r  <= '0;
            rnd_r <= '0;
        end else if (state_r == eIdle && v_i) begin
            st_r  <= data_i ^ w_i[0 +: block_w_lp];
            rk_r  <= w_i;
            rnd_r <= rnd_w_lp'(1);
        end else if (state_r == eRound) begin
            st_r  <= round_out;
            rnd_r <= last_round ? '0 : rnd_r + rnd_w_lp'(1);
        end
    end

    // Bus reads zero outside DONE so intermediate round states never leak out.
    assign data_o = v_o ? st_r : '0;

endmodule

// File: tb/tb_aes256_round_engine.sv
// Scoreboard bench for aes256_round_engine with an independent AES-256 software model.
module tb_aes256_round_engine;

    logic           clk = 1'b0;
    logic           reset, v_i, ready_o, v_o, yumi_i;
    logic [127:0]   data_i, data_o;
    logic [0:1919]  w_i;

    aes256_round_engine dut (
        .clk_i   (clk),
        .reset_i (reset),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .w_i     (w_i),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] data; int acc_cyc; } exp_t;

    exp_t         sb_q[$];
    int           total = 0, bad = 0, cyc = 0, n_out = 0;
    bit           yumi_en = 1'b0;
    logic [7:0]   sb_tab [256];

    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_FIPS  = 128'h8ea2b7ca516745bfeafc49904b496089;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse plus affine map, independent of any table.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb_tab[x[31:24]], sb_tab[x[23:16]], sb_tab[x[15:8]], sb_tab[x[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1919] s;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) s[32*i +: 32] = w[i];
        return s;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [0:1919] ks);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ ks[0 +: 128];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sb_tab[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[row + 4*c] = b[row + 4*((c + row) % 4)];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                b = t;
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = b[i];
            st = st ^ ks[128*r +: 128];
        end
        return st;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [127:0] pt, input logic [0:1919] ks,
                        input logic [127:0] exp, output int acc);
        int n = 0;
        v_i = 1'b1; data_i = pt; w_i = ks;
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        acc = cyc + 1;
        if (!ready_o) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready_o=0 expected ready_o=1 within 200 cycles");
        end else begin
            sb_q.push_back('{exp, acc});
        end
        @(negedge clk);
        chk("busy_after_accept", ready_o, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || !ready_o) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            yumi_i = v_o && yumi_en;
        end
    end

    // Monitor: pops on each rising v_o, checks data, latency and stability while held.
    initial begin
        logic         prev_v;
        logic [127:0] held;
        exp_t         e;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (v_o && !prev_v) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: got %h expected no output", data_o);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ciphertext", data_o, e.data);
                        chk("latency", cyc - e.acc_cyc, 14);
                    end
                    held = data_o;
                end else if (v_o) begin
                    chk("hold_stable", data_o, held);
                end
                prev_v = v_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int            a0, a1, n, vcount;
        logic [0:1919] ks_fips, ks_zero, ks;
        logic [127:0]  pt;
        logic [255:0]  key;

        reset = 1'b1; v_i = 1'b0; data_i = '0; w_i = '0;
        init_sbox();
        ks_fips = expand(KEY_FIPS);
        ks_zero = expand('0);
        repeat (3) @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_v", v_o, 0);
        chk("reset_data", data_o, '0);
        reset   = 1'b0;
        yumi_en = 1'b1;
        @(negedge clk);

        // FIPS-197 C.3
        send(PT_FIPS, ks_fips, CT_FIPS, a0);
        v_i = 1'b0;
        wait_drain();

        // Schedule swapped right after accept must not disturb the block in flight
        send(PT_FIPS, ks_fips, CT_FIPS, a0);
        v_i = 1'b0; w_i = ks_zero; data_i = '1;
        wait_drain();

        // Back-pressure: hold off yumi for 20 cycles while a second block waits on v_i
        yumi_en = 1'b0;
        send(PT_FIPS, ks_fips, CT_FIPS, a0);
        v_i = 1'b0;
        n = 0;
        while (!v_o && n < 40) begin @(negedge clk); n++; end
        chk("bp_v_seen", v_o, 1);
        fork
            send(PT_FIPS, ks_zero, enc(PT_FIPS, ks_zero), a1);
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk("bp_ready_low", ready_o, 0);
                end
                yumi_en = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_ready_after_yumi", ready_o, 1);
                chk("bp_v_after_yumi", v_o, 0);
            end
        join
        v_i = 1'b0;
        wait_drain();

        // Reset in ROUND cycle 7 drops the block
        send(PT_FIPS, ks_fips, CT_FIPS, a0);
        v_i = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("midreset_ready", ready_o, 1);
        chk("midreset_v", v_o, 0);
        chk("midreset_data", data_o, '0);
        reset  = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (v_o) vcount++;
        end
        chk("midreset_no_output", vcount, 0);

        // Back-to-back random blocks with v_i held high throughout
        for (int k = 0; k < 4; k++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            ks  = expand(key);
            send(pt, ks, enc(pt, ks), a1);
            if (k > 0) chk("b2b_spacing", a1 - a0, 16);
            a0 = a1;
        end
        v_i = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        chk("output_count", n_out, 8);
        chk("queue_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
